pwl_interp_seq: RTL

//  Sequential piecewise-linear interpolator over a runtime-loadable table of NUM_POINTS
//  (x,y) breakpoints. Accepts one x per transaction via valid/ready, scans for the segment,

---
 rtl/pwl_interp_seq.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/pwl_interp_seq.sv
// Sequential piecewise-linear interpolator over a runtime-loadable breakpoint table.
// Ports: clk/rst (sync, active-high); tbl_we/tbl_addr/tbl_x/tbl_y table write, tbl_err
// pulses when a write is dropped; in_valid/in_ready/in_x query input; out_valid/out_ready/
// out_y/out_clamped result; busy while a transaction is in flight.
module pwl_interp_seq #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_POINTS = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tbl_we,
    input  logic [ADDR_WIDTH-1:0] tbl_addr,
    input  logic [DATA_WIDTH-1:0] tbl_x,
    input  logic [DATA_WIDTH-1:0] tbl_y,
    output logic                  tbl_err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic                  out_clamped,
    output logic                  busy
);
    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned NUM_W = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_DIV, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          tbl_x_q [NUM_POINTS];
    logic [W-1:0]          tbl_x_d [NUM_POINTS];
    logic [W-1:0]          tbl_y_q [NUM_POINTS];
    logic [W-1:0]          tbl_y_d [NUM_POINTS];
    logic [W-1:0]          x_q, x_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] seg_q, seg_d;
    logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
    logic [W-1:0]          rem_q, rem_d;
    logic [W-1:0]          lo_q, lo_d;
    logic [W-1:0]          quo_q, quo_d;
    logic [W-1:0]          den_q, den_d;
    logic [W-1:0]          base_q, base_d;
    logic                  neg_q, neg_d;
    logic                  forced_q, forced_d;
    logic                  clamp_q, clamp_d;
    logic                  tbl_err_q, tbl_err_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [W-1:0]          out_y_q, out_y_d;
    logic                  out_clamped_q, out_clamped_d;
    logic                  busy_q, busy_d;

    // Segment selection including this cycle's comparison, and the operands it implies
    logic [ADDR_WIDTH-1:0] seg_fin, seg_nxt;
    logic [W-1:0]          op_x0, op_x1, op_y0, op_y1, op_dx, op_dy, op_den;
    logic [NUM_W-1:0]      op_num;
    logic                  op_neg, clamp_lo, clamp_hi, addr_ok, wr_ok;

    assign seg_fin  = (tbl_x_q[cnt_q] <= x_q) ? cnt_q : seg_q;
    assign seg_nxt  = seg_fin + ADDR_WIDTH'(1);
    assign op_x0    = tbl_x_q[seg_fin];
    assign op_x1    = tbl_x_q[seg_nxt];
    assign op_y0    = tbl_y_q[seg_fin];
    assign op_y1    = tbl_y_q[seg_nxt];
    assign op_neg   = op_y1 < op_y0;
    assign op_dx    = x_q - op_x0;
    assign op_dy    = op_neg ? (op_y0 - op_y1) : (op_y1 - op_y0);
    assign op_den   = op_x1 - op_x0;
    assign op_num   = NUM_W'(op_dx) * NUM_W'(op_dy);
    assign clamp_lo = x_q < tbl_x_q[0];
    assign clamp_hi = x_q > tbl_x_q[NUM_POINTS-1];
    assign addr_ok  = 32'(tbl_addr) < NUM_POINTS;
    assign wr_ok    = tbl_we && (state_q == ST_IDLE) && addr_ok;

    // Restoring divider step: remainder stays below den, so W+1 bits suffice for the trial
    logic [W:0] div_trial, div_sub;
    logic       div_ge;
    logic [W-1:0] res_y;

    assign div_trial = {rem_q, lo_q[W-1]};
    assign div_ge    = div_trial >= {1'b0, den_q};
    assign div_sub   = div_trial - {1'b0, den_q};
    assign res_y     = forced_q ? base_q : (neg_q ? (base_q - quo_q) : (base_q + quo_q));

    // Next-state, datapath and output logic
    always_comb begin
        state_d       = state_q;
        tbl_x_d       = tbl_x_q;
        tbl_y_d       = tbl_y_q;
        x_d           = x_q;
        cnt_d         = cnt_q;
        seg_d         = seg_q;
        div_cnt_d     = div_cnt_q;
        rem_d         = rem_q;
        lo_d          = lo_q;
        quo_d         = quo_q;
        den_d         = den_q;
        base_d        = base_q;
        neg_d         = neg_q;
        forced_d      = forced_q;
        clamp_d       = clamp_q;
        out_valid_d   = out_valid_q;
        out_y_d       = out_y_q;
        out_clamped_d = out_clamped_q;
        tbl_err_d     = tbl_we && !wr_ok;

        if (wr_ok) begin
            tbl_x_d[tbl_addr] = tbl_x;
            tbl_y_d[tbl_addr] = tbl_y;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d     = in_x;
                    cnt_d   = '0;
                    seg_d   = '0;
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                seg_d = seg_fin;
                if (cnt_q == ADDR_WIDTH'(NUM_POINTS - 2)) begin
                    rem_d     = op_num[NUM_W-1:W];
                    lo_d      = op_num[W-1:0];
                    quo_d     = '0;
                    den_d     = op_den;
                    neg_d     = op_neg;
                    div_cnt_d = '0;
                    clamp_d   = clamp_lo || clamp_hi;
                    forced_d  = clamp_lo || clamp_hi || (op_den == '0);
                    if (clamp_lo)      base_d = tbl_y_q[0];
                    else if (clamp_hi) base_d = tbl_y_q[NUM_POINTS-1];
                    else               base_d = op_y0;
                    state_d   = ST_DIV;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_DIV: begin
                rem_d = div_ge ? W'(div_sub) : W'(div_trial);
                lo_d  = {lo_q[W-2:0], 1'b0};
                quo_d = {quo_q[W-2:0], div_ge};
                if (div_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    div_cnt_d = div_cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // First DONE cycle registers the result; it then holds until accepted
                if (!out_valid_q) begin
                    out_valid_d   = 1'b1;
                    out_y_d       = res_y;
                    out_clamped_d = clamp_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            for (int i = 0; i < int'(NUM_POINTS); i++) begin
                tbl_x_q[i] <= '0;
                tbl_y_q[i] <= '0;
            end
            x_q           <= '0;
            cnt_q         <= '0;
            seg_q         <= '0;
            div_cnt_q     <= '0;
            rem_q         <= '0;
            lo_q          <= '0;
            quo_q         <= '0;
            den_q         <= '0;
            base_q        <= '0;
            neg_q         <= 1'b0;
            forced_q      <= 1'b0;
            clamp_q       <= 1'b0;
            tbl_err_q     <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_y_q       <= '0;
            out_clamped_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tbl_x_q       <= tbl_x_d;
            tbl_y_q       <= tbl_y_d;
            x_q           <= x_d;
            cnt_q         <= cnt_d;
            seg_q         <= seg_d;
            div_cnt_q     <= div_cnt_d;
            rem_q         <= rem_d;
            lo_q          <= lo_d;
            quo_q         <= quo_d;
            den_q         <= den_d;
            base_q        <= base_d;
            neg_q         <= neg_d;
            forced_q      <= forced_d;
            clamp_q       <= clamp_d;
            tbl_err_q     <= tbl_err_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_y_q       <= out_y_d;
            out_clamped_q <= out_clamped_d;
            busy_q        <= busy_d;
        end
    end

    assign tbl_err     = tbl_err_q;
    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_y       = out_y_q;
    assign out_clamped = out_clamped_q;
    assign busy        = busy_q;

endmodule
